// File: rtl/prefix_call_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : prefix_call_sequencer
// Brief    : DD/FD/ED prefix state holder and multi-cycle CALL nn sequencer.
// Revision : 1.0
// ============================================================================
module prefix_call_sequencer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p2_set_icallnn_0,
    input  logic              p2_set_xix,
    input  logic              p2_set_xiy,
    input  logic              p2_set_xotr,
    input  logic              instr_end,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pfx_ix,
    output logic              pfx_iy,
    output logic              pfx_ed,
    output logic              busy,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              addr_sel,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              pc_inc,
    output logic              sp_dec,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              call_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_LO = 3'd1,
        S_RD_HI = 3'd2,
        S_DEC_H = 3'd3,
        S_WR_H  = 3'd4,
        S_DEC_L = 3'd5,
        S_WR_L  = 3'd6,
        S_JUMP  = 3'd7
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_hi;
    logic              r_ix;
    logic              r_iy;
    logic              r_ed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs are decoded from state so an async reset silences them at once.
    always_comb begin
        w_next    = r_state;
        busy      = 1'b1;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        addr_sel  = 1'b0;
        mem_wdata = '0;
        pc_inc    = 1'b0;
        sp_dec    = 1'b0;
        pc_load   = 1'b0;
        call_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (p2_set_icallnn_0) begin
                    w_next = S_RD_LO;
                end
            end
            S_RD_LO: begin
                mem_rd = 1'b1;
                pc_inc = mem_ready;
                if (mem_ready) begin
                    w_next = S_RD_HI;
                end
            end
            S_RD_HI: begin
                mem_rd = 1'b1;
                pc_inc = mem_ready;
                if (mem_ready) begin
                    w_next = S_DEC_H;
                end
            end
            S_DEC_H: begin
                sp_dec = 1'b1;
                w_next = S_WR_H;
            end
            S_WR_H: begin
                mem_wr    = 1'b1;
                addr_sel  = 1'b1;
                mem_wdata = pc_in[ADDR_W-1 -: DATA_W];
                if (mem_ready) begin
                    w_next = S_DEC_L;
                end
            end
            S_DEC_L: begin
                sp_dec = 1'b1;
                w_next = S_WR_L;
            end
            S_WR_L: begin
                mem_wr    = 1'b1;
                addr_sel  = 1'b1;
                mem_wdata = pc_in[DATA_W-1:0];
                if (mem_ready) begin
                    w_next = S_JUMP;
                end
            end
            S_JUMP: begin
                pc_load   = 1'b1;
                call_done = 1'b1;
                w_next    = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lo <= '0;
            r_hi <= '0;
        end else begin
            if (r_state == S_RD_LO && mem_ready) begin
                r_lo <= mem_rdata;
            end
            if (r_state == S_RD_HI && mem_ready) begin
                r_hi <= mem_rdata;
            end
        end
    end

    // A set strobe outranks the clear; strobes are dropped during a CALL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ix <= 1'b0;
            r_iy <= 1'b0;
            r_ed <= 1'b0;
        end else if (!busy && p2_set_xotr) begin
            r_ix <= 1'b0;
            r_iy <= 1'b0;
            r_ed <= 1'b1;
        end else if (!busy && p2_set_xiy) begin
            r_ix <= 1'b0;
            r_iy <= 1'b1;
            r_ed <= 1'b0;
        end else if (!busy && p2_set_xix) begin
            r_ix <= 1'b1;
            r_iy <= 1'b0;
            r_ed <= 1'b0;
        end else if (instr_end || call_done) begin
            r_ix <= 1'b0;
            r_iy <= 1'b0;
            r_ed <= 1'b0;
        end
    end

    assign pfx_ix    = r_ix;
    assign pfx_iy    = r_iy;
    assign pfx_ed    = r_ed;
    assign pc_target = ADDR_W'({r_hi, r_lo});

endmodule
`default_nettype wire

// File: doc/prefix_call_sequencer.md
Name: prefix_call_sequencer

Overview:
- Sits directly downstream of the 11xx1101 opcode decoder and consumes its P2 set strobes.
- Holds the DD/FD/ED prefix state (IX, IY, ED) across opcode fetches.
- Runs the multi-cycle CALL nn sequence when the decoder fires the CALL strobe:
  - read operand low byte, then high byte;
  - push PCH, then PCL;
  - load PC with the operand.
- Drives the memory request/handshake and the PC/SP control pulses consumed by the register file.

Parameters:
- ADDR_W, 16, width of PC and target address.
- DATA_W, 8, width of memory data bus.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- p2_set_icallnn_0  in  1  decoder strobe: CALL nn opcode decoded.
- p2_set_xix  in  1  decoder strobe: DD prefix.
- p2_set_xiy  in  1  decoder strobe: FD prefix.
- p2_set_xotr  in  1  decoder strobe: ED prefix.
- instr_end  in  1  non-prefix instruction completed; clears prefix state.
- mem_ready  in  1  memory handshake; a request completes on a cycle where the request and mem_ready are both high.
- mem_rdata  in  DATA_W  read data, valid with mem_ready.
- pc_in  in  ADDR_W  current PC (already past the operand bytes when pushed).
- pfx_ix  out  1  IX prefix active.
- pfx_iy  out  1  IY prefix active.
- pfx_ed  out  1  ED prefix active.
- busy  out  1  CALL sequence in progress.
- mem_rd  out  1  read request.
- mem_wr  out  1  write request.
- addr_sel  out  1  0 = PC addresses memory, 1 = SP addresses memory.
- mem_wdata  out  DATA_W  write data.
- pc_inc  out  1  one-cycle pulse: PC += 1.
- sp_dec  out  1  one-cycle pulse: SP -= 1.
- pc_load  out  1  one-cycle pulse: PC <= pc_target.
- pc_target  out  ADDR_W  latched operand {hi,lo}.
- call_done  out  1  one-cycle pulse at end of CALL.

Behaviour:
- Reset (async, active-high):
  - State IDLE; all outputs 0; pc_target = 0; operand latch = 0.
  - Reset asserted mid-sequence aborts the sequence immediately; no further pulses are issued.
- Prefix register:
  - p2_set_xix → ix=1, iy=0, ed=0.
  - p2_set_xiy → iy=1, ix=0, ed=0.
  - p2_set_xotr → ed=1, ix=0, iy=0.
  - If several strobes are high in one cycle, priority is xotr > xiy > xix. A simultaneous p2_set_icallnn_0 still starts the CALL.
  - instr_end or call_done clears all three flags next edge. A set strobe in the same cycle wins over instr_end.
  - Prefix strobes are ignored while busy.
- CALL FSM states: IDLE, RD_LO, RD_HI, DEC_H, WR_H, DEC_L, WR_L, JUMP.
- IDLE:
  - p2_set_icallnn_0 → RD_LO on the next edge.
  - busy=1 from RD_LO onward.
  - The strobe is ignored when not in IDLE.
- RD_LO: mem_rd=1, addr_sel=0. On mem_ready:
  - latch lo = mem_rdata;
  - pulse pc_inc;
  - → RD_HI.
- RD_HI: same as RD_LO, latching hi; → DEC_H.
- DEC_H: sp_dec pulse for one cycle; → WR_H.
- WR_H: mem_wr=1, addr_sel=1, mem_wdata = pc_in[15:8]. On mem_ready → DEC_L.
- DEC_L: sp_dec pulse; → WR_L.
- WR_L: mem_wr=1, addr_sel=1, mem_wdata = pc_in[7:0]. On mem_ready → JUMP.
- JUMP:
  - pc_target = {hi,lo} (stable from RD_HI completion onward);
  - pc_load=1 and call_done=1 for exactly one cycle;
  - → IDLE, busy=0 next cycle.
- Requests are held high until mem_ready is seen. mem_ready while no request is active is ignored.
- mem_rd and mem_wr are never high together. pc_inc, sp_dec and pc_load are never high together.
- Minimum latency with zero wait states: strobe at cycle n → pc_load at cycle n+7.

Test Plan:
- Reset, then a CALL strobe with mem_ready tied 1:
  - mem_rdata 0x34 then 0x12; pc_in = 0x0103.
  - Writes 0x01 then 0x03 with addr_sel=1.
  - pc_target = 0x1234; pc_load at strobe+7; exactly two pc_inc and two sp_dec pulses.
- The same CALL with mem_ready low for 3 cycles in RD_HI and 2 cycles in WR_L:
  - requests are held for those cycles;
  - pc_load arrives at strobe+12;
  - latched data is unchanged by wait cycles.
- Prefix sequence:
  - p2_set_xix → pfx_ix=1.
  - Then p2_set_xotr → ed=1, ix=0.
  - Then instr_end → all flags 0.
  - xix and xiy in the same cycle → iy=1, ix=0.
- Prefixed CALL (xix, then CALL):
  - pfx_ix stays 1 during busy;
  - a p2_set_xiy mid-sequence is ignored;
  - all flags clear the cycle after call_done.
- Reset asserted during WR_H:
  - outputs go 0 asynchronously, without waiting for a clock edge;
  - after release, state is IDLE, no pc_load occurs, and a fresh CALL completes normally.
- A second p2_set_icallnn_0 while busy:
  - is ignored;
  - exactly one call_done pulse is produced.
